// File: rtl/serial_add_sub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: operands are latched on start and consumed LSB-first through one 1-bit add/sub cell.
// Optional signed-overflow output ovf_out is enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             opcode_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_out,
`ifdef SERIAL_ADD_SUB_OVF_EN
  output logic             ovf_out,
`endif
  output logic             flag_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_q, flag_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // The 1-bit cell: subtraction inverts b and seeds the carry with 1.
  logic bit_a, bit_b, sum_bit, carry_nxt, last_bit;
  assign bit_a     = a_q[cnt_q];
  assign bit_b     = b_q[cnt_q] ^ op_q;
  assign sum_bit   = bit_a ^ bit_b ^ carry_q;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    result_d = result_q;
    flag_d   = flag_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = opcode_in;
          cnt_d   = '0;
          carry_d = opcode_in;
          sum_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_d = carry_nxt;
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        // Results are published only here so they stay stable throughout SHIFT.
        if (last_bit) begin
          cnt_d    = '0;
          state_d  = DONE;
          result_d = {sum_bit, sum_q[WIDTH-1:1]};
          flag_d   = op_q ? ~carry_nxt : carry_nxt;
`ifdef SERIAL_ADD_SUB_OVF_EN
          ovf_d    = carry_q ^ carry_nxt;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      flag_q   <= flag_d;
`ifdef SERIAL_ADD_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy_out   = (state_q == SHIFT);
  assign done_out   = (state_q == DONE);
  assign result_out = result_q;
  assign flag_out   = flag_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign ovf_out    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit (WIDTH=8); expected results are queued at start and checked on done.
module tb_serial_add_sub_unit;

   typedef struct {
      logic [7:0] result;
      logic       flag;
      logic       ovf;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       opcode = 1'b0;
   logic [7:0] aIn = 8'h00;
   logic [7:0] bIn = 8'h00;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       flag;
`ifdef SERIAL_ADD_SUB_OVF_EN
   logic       ovf;
`endif

   expect_t    scoreboard[$];
   int         testsRun = 0;
   int         testsFailed = 0;
   logic [7:0] lastResult = 8'h00;

   serial_add_sub_unit #(.WIDTH(8)) dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .start_in   (start),
      .opcode_in  (opcode),
      .a_in       (aIn),
      .b_in       (bIn),
      .busy_out   (busy),
      .done_out   (done),
      .result_out (result),
`ifdef SERIAL_ADD_SUB_OVF_EN
      .ovf_out    (ovf),
`endif
      .flag_out   (flag)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any disagreement
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model of the unsigned add/sub with carry/borrow and signed overflow
   function automatic expect_t model(input logic op, input logic [7:0] a, input logic [7:0] b);
      expect_t    e;
      logic [8:0] wide;
      if (op) begin
         wide = {1'b0, a} - {1'b0, b};
         e.flag = (a < b);
         e.ovf = (a[7] != b[7]) && (wide[7] != a[7]);
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         e.flag = wide[8];
         e.ovf = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      e.result = wide[7:0];
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (done) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            expect_t e;
            e = scoreboard.pop_front();
            checkOutput("result", 32'(result), 32'(e.result));
            checkOutput("flag", 32'(flag), 32'(e.flag));
`ifdef SERIAL_ADD_SUB_OVF_EN
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // Drives one operation, optionally pokes a second start mid-SHIFT, and checks timing and stability
   task automatic applyStimulus(input logic op, input logic [7:0] a, input logic [7:0] b, input bit pokeStart);
      int   cyc;
      int   busyCycles;
      bit   doneSeen;
      expect_t e;
      @(negedge clk);
      start = 1'b1;
      opcode = op;
      aIn = a;
      bIn = b;
      e = model(op, a, b);
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      aIn = 8'($urandom);
      bIn = 8'($urandom);
      opcode = ~op;
      cyc = 0;
      busyCycles = 0;
      doneSeen = 1'b0;
      while (!doneSeen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (busy) busyCycles++;
         if (done) doneSeen = 1'b1;
         if (cyc == 4) begin
            checkOutput("result_stable_in_shift", 32'(result), 32'(lastResult));
            if (pokeStart) begin
               start = 1'b1;
               opcode = 1'b0;
               aIn = 8'hAA;
               bIn = 8'h11;
            end
         end
         if (cyc == 5) start = 1'b0;
      end
      checkOutput("done_seen", 32'(doneSeen), 32'd1);
      checkOutput("done_cycle", 32'(cyc), 32'd9);
      checkOutput("busy_cycles", 32'(busyCycles), 32'd8);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_not_busy", 32'(busy), 32'd0);
      checkOutput("result_held", 32'(result), 32'(e.result));
      lastResult = e.result;
   endtask

   initial begin
      int idleCycles;
      bit spurious;

      // Reset held for three cycles
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_flag", 32'(flag), 32'd0);
      rst = 1'b0;

      applyStimulus(1'b0, 8'h3C, 8'h05, 1'b0);
      applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h05, 8'h06, 1'b0);
      applyStimulus(1'b1, 8'h06, 8'h05, 1'b1);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b0);
`ifdef SERIAL_ADD_SUB_OVF_EN
      applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
      applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);
`endif

      // Reset in cycle 4 of an add must abort without a done pulse
      @(negedge clk);
      start = 1'b1;
      opcode = 1'b0;
      aIn = 8'h12;
      bIn = 8'h34;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_flag", 32'(flag), 32'd0);
      lastResult = 8'h00;
      spurious = 1'b0;
      for (idleCycles = 0; idleCycles < 12; idleCycles++) begin
         @(negedge clk);
         if (done || busy) spurious = 1'b1;
      end
      checkOutput("abort_stays_idle", 32'(spurious), 32'd0);

      applyStimulus(1'b0, 8'hC8, 8'h64, 1'b0);

      // Random operations
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      @(negedge clk);
      checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
